// File: rtl/lcd_pkg.sv
// Shared HD44780 constants, controller state encoding and clock-derived cycle counts.
package lcd_pkg;

    localparam logic [7:0] CMD_CLEAR = 8'h01;
    localparam logic [7:0] CMD_ENTRY = 8'h06;
    localparam logic [7:0] CMD_DISP  = 8'h0C;
    localparam logic [7:0] CMD_FSET  = 8'h38;
    localparam logic [7:0] CMD_DDRAM = 8'h80;
    localparam logic [7:0] ROW1_BASE = 8'h40;

    typedef enum logic [2:0] {
        ST_PWRUP, ST_FS1, ST_FS2, ST_FS3, ST_DISP, ST_CLEAR, ST_ENTRY, ST_REFRESH
    } lcd_state_e;

    // Rounds up so a wait is never shorter than the controller minimum.
    function automatic int ns_to_cyc(input int clk_hz, input int ns);
        longint prod;
        prod = longint'(clk_hz) * longint'(ns) + longint'(999_999_999);
        return int'(prod / longint'(1_000_000_000));
    endfunction

    function automatic int en_cyc(input int clk_hz);
        return clk_hz / 4_000_000 + 1;
    endfunction

    function automatic logic [7:0] row_base(input logic [1:0] row, input int cols);
        case (row)
            2'd0:    return 8'h00;
            2'd1:    return ROW1_BASE;
            2'd2:    return 8'(cols);
            default: return ROW1_BASE + 8'(cols);
        endcase
    endfunction

endpackage

// File: rtl/lcd_bus_writer.sv
// One HD44780 bus write: setup, EN pulse, hold, then the post-write execution wait.
module lcd_bus_writer
    import lcd_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       rs,
    input  logic [7:0] data,
    input  logic       long_wait,
    output logic       busy,
    output logic       lcd_rs,
    output logic       lcd_en,
    output logic [7:0] lcd_data
);

    localparam int EN_CYC  = en_cyc(CLK_HZ);
    localparam int T_SHORT = ns_to_cyc(CLK_HZ, 40_000);
    localparam int T_LONG  = ns_to_cyc(CLK_HZ, 1_640_000);
    localparam int CNT_W   = $clog2(T_LONG + 1);

    localparam logic [2:0] PH_IDLE  = 3'd0;
    localparam logic [2:0] PH_SETUP = 3'd1;
    localparam logic [2:0] PH_EN    = 3'd2;
    localparam logic [2:0] PH_HOLD  = 3'd3;
    localparam logic [2:0] PH_WAIT  = 3'd4;

    logic [2:0]       phase;
    logic [CNT_W-1:0] cnt;
    logic             long_q;

    assign busy = (phase != PH_IDLE);

    // RS/DATA stay latched until the next start, covering setup and hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase    <= PH_IDLE;
            cnt      <= '0;
            long_q   <= 1'b0;
            lcd_rs   <= 1'b0;
            lcd_en   <= 1'b0;
            lcd_data <= 8'h00;
        end else begin
            case (phase)
                PH_IDLE: begin
                    if (start) begin
                        lcd_rs   <= rs;
                        lcd_data <= data;
                        long_q   <= long_wait;
                        phase    <= PH_SETUP;
                    end
                end
                PH_SETUP: begin
                    lcd_en <= 1'b1;
                    cnt    <= CNT_W'(EN_CYC - 1);
                    phase  <= PH_EN;
                end
                PH_EN: begin
                    if (cnt == '0) begin
                        lcd_en <= 1'b0;
                        phase  <= PH_HOLD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                PH_HOLD: begin
                    cnt   <= long_q ? CNT_W'(T_LONG - 1) : CNT_W'(T_SHORT - 1);
                    phase <= PH_WAIT;
                end
                PH_WAIT: begin
                    if (cnt == '0) phase <= PH_IDLE;
                    else           cnt   <= cnt - 1'b1;
                end
                default: phase <= PH_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/lcd_frame_driver.sv
// Character frame buffer with HD44780 init sequencer and continuous display refresh.
module lcd_frame_driver
    import lcd_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int ROWS   = 2,
    parameter int COLS   = 16
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic       wr_en,
    input  logic [1:0] wr_row,
    input  logic [5:0] wr_col,
    input  logic [7:0] wr_char,
    input  logic       clr,
    output logic       wr_ready,
    output logic       wr_err,
    output logic       init_done,
    output logic       frame_pulse,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic       LCD_EN,
    output logic [7:0] LCD_DATA
);

    localparam int NCELL   = ROWS * COLS;
    localparam int IDX_W   = $clog2(NCELL);
    localparam int T_SHORT = ns_to_cyc(CLK_HZ, 40_000);
    localparam int T_PWRUP = ns_to_cyc(CLK_HZ, 15_000_000);
    localparam int X_FS1   = ns_to_cyc(CLK_HZ, 4_100_000) - T_SHORT;
    localparam int X_FS2   = ns_to_cyc(CLK_HZ, 100_000) - T_SHORT;
    localparam int DLY_W   = $clog2(T_PWRUP + 1);

    logic [7:0]       fb [NCELL];
    logic             clr_active;
    logic [IDX_W-1:0] clr_idx;
    logic             wr_acc;
    logic             wr_in_range;
    logic [IDX_W-1:0] wr_idx;

    lcd_state_e       state;
    lcd_state_e       next_st;
    int               extra_cyc;
    logic             issued;
    logic [DLY_W-1:0] dly;
    logic [1:0]       row;
    logic [5:0]       col;
    logic             cmd_ph;
    logic [IDX_W-1:0] rd_idx;

    logic             bw_start;
    logic             bw_rs;
    logic             bw_long;
    logic [7:0]       bw_data;
    logic             bw_busy;
    logic             bw_done;

    assign LCD_RW      = 1'b0;
    assign wr_ready    = !clr_active;
    assign wr_acc      = wr_en && wr_ready;
    assign wr_in_range = (int'(wr_row) < ROWS) && (int'(wr_col) < COLS);
    assign wr_idx      = IDX_W'(int'(wr_row) * COLS + int'(wr_col));
    assign rd_idx      = IDX_W'(int'(row) * COLS + int'(col));

    always_ff @(posedge CLOCK_50) begin
        if (clr_active)
            fb[clr_idx] <= 8'h20;
        else if (wr_acc && wr_in_range)
            fb[wr_idx] <= wr_char;
    end

    // Reset starts a clear so the buffer never shows power-on garbage.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            clr_active <= 1'b1;
            clr_idx    <= '0;
            wr_err     <= 1'b0;
        end else begin
            wr_err <= wr_acc && !wr_in_range;
            if (clr_active) begin
                if (int'(clr_idx) == NCELL - 1) clr_active <= 1'b0;
                clr_idx <= clr_idx + 1'b1;
            end else if (clr) begin
                clr_active <= 1'b1;
                clr_idx    <= '0;
            end
        end
    end

    always_comb begin
        bw_rs     = 1'b0;
        bw_long   = 1'b0;
        bw_data   = 8'h00;
        next_st   = state;
        extra_cyc = 0;
        case (state)
            ST_FS1:     begin bw_data = CMD_FSET;  next_st = ST_FS2;  extra_cyc = X_FS1; end
            ST_FS2:     begin bw_data = CMD_FSET;  next_st = ST_FS3;  extra_cyc = X_FS2; end
            ST_FS3:     begin bw_data = CMD_FSET;  next_st = ST_DISP;  end
            ST_DISP:    begin bw_data = CMD_DISP;  next_st = ST_CLEAR; end
            ST_CLEAR:   begin bw_data = CMD_CLEAR; bw_long = 1'b1; next_st = ST_ENTRY; end
            ST_ENTRY:   begin bw_data = CMD_ENTRY; next_st = ST_REFRESH; end
            ST_REFRESH: begin
                if (cmd_ph) begin
                    bw_data = CMD_DDRAM | row_base(row, COLS);
                end else begin
                    bw_rs   = 1'b1;
                    bw_data = fb[rd_idx];
                end
            end
            default: ;
        endcase
    end

    // The writer latches bw_data on start, so each byte is sampled when its write begins.
    assign bw_start = (state != ST_PWRUP) && !issued && !bw_busy;
    assign bw_done  = issued && !bw_busy;

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state       <= ST_PWRUP;
            issued      <= 1'b0;
            dly         <= '0;
            row         <= '0;
            col         <= '0;
            cmd_ph      <= 1'b1;
            init_done   <= 1'b0;
            frame_pulse <= 1'b0;
        end else begin
            frame_pulse <= 1'b0;
            if (bw_start) issued <= 1'b1;
            case (state)
                ST_PWRUP: begin
                    if (int'(dly) >= T_PWRUP - 1) begin
                        dly   <= '0;
                        state <= ST_FS1;
                    end else begin
                        dly <= dly + 1'b1;
                    end
                end
                ST_REFRESH: begin
                    if (bw_done) begin
                        issued <= 1'b0;
                        if (cmd_ph) begin
                            cmd_ph <= 1'b0;
                            col    <= '0;
                        end else if (int'(col) == COLS - 1) begin
                            cmd_ph <= 1'b1;
                            if (int'(row) == ROWS - 1) begin
                                row         <= '0;
                                frame_pulse <= 1'b1;
                            end else begin
                                row <= row + 1'b1;
                            end
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                default: begin
                    if (bw_done) begin
                        if (int'(dly) < extra_cyc) begin
                            dly <= dly + 1'b1;
                        end else begin
                            dly    <= '0;
                            issued <= 1'b0;
                            state  <= next_st;
                            if (next_st == ST_REFRESH) init_done <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    lcd_bus_writer #(.CLK_HZ(CLK_HZ)) u_bus (
        .clk       (CLOCK_50),
        .rst       (RESET),
        .start     (bw_start),
        .rs        (bw_rs),
        .data      (bw_data),
        .long_wait (bw_long),
        .busy      (bw_busy),
        .lcd_rs    (LCD_RS),
        .lcd_en    (LCD_EN),
        .lcd_data  (LCD_DATA)
    );

endmodule

// File: tb/tb_lcd_frame_driver.sv
// Directed bench for lcd_frame_driver at 1 MHz, 2x16 characters.
`timescale 1ns/1ps
module tb_lcd_frame_driver;

    localparam int CLK_HZ = 1_000_000;
    localparam int ROWS   = 2;
    localparam int COLS   = 16;
    localparam int NW     = ROWS * (COLS + 1);

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic       clr = 1'b0;
    logic [1:0] wr_row = 2'd0;
    logic [5:0] wr_col = 6'd0;
    logic [7:0] wr_char = 8'h00;
    logic       wr_ready, wr_err, init_done, frame_pulse;
    logic       lcd_rs, lcd_rw, lcd_en;
    logic [7:0] lcd_data;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int rel = 0;
    int setup_viol = 0;
    int rw_viol = 0;

    logic [9:0] evq [$];
    int         evc [$];
    int         en_lens [$];
    logic [8:0] frame [NW];
    bit         fp_after;
    logic [7:0] model [ROWS*COLS];

    lcd_frame_driver #(.CLK_HZ(CLK_HZ), .ROWS(ROWS), .COLS(COLS)) dut (
        .CLOCK_50    (clk),
        .RESET       (rst),
        .wr_en       (wr_en),
        .wr_row      (wr_row),
        .wr_col      (wr_col),
        .wr_char     (wr_char),
        .clr         (clr),
        .wr_ready    (wr_ready),
        .wr_err      (wr_err),
        .init_done   (init_done),
        .frame_pulse (frame_pulse),
        .LCD_RS      (lcd_rs),
        .LCD_RW      (lcd_rw),
        .LCD_EN      (lcd_en),
        .LCD_DATA    (lcd_data)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // Bus monitor: logs EN rises as {0,rs,data}, frame pulses as 10'h200.
    initial begin
        logic       prev_en;
        logic       prev_rs;
        logic [7:0] prev_data;
        int         en_len;
        prev_en = 1'b0; prev_rs = 1'b0; prev_data = 8'h00; en_len = 0;
        forever begin
            @(negedge clk);
            if (lcd_rw !== 1'b0) rw_viol++;
            if (frame_pulse === 1'b1) begin
                evq.push_back(10'h200);
                evc.push_back(cyc);
            end
            if (lcd_en && !prev_en) begin
                if (lcd_rs !== prev_rs || lcd_data !== prev_data) setup_viol++;
                evq.push_back({1'b0, lcd_rs, lcd_data});
                evc.push_back(cyc);
                en_len = 1;
            end else if (lcd_en) begin
                en_len++;
            end else if (prev_en) begin
                en_lens.push_back(en_len);
            end
            prev_en = lcd_en; prev_rs = lcd_rs; prev_data = lcd_data;
        end
    end

    initial begin
        #950_000;
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    task automatic get_ev(input int lim, output bit ok, output logic [9:0] e, output int c);
        int t;
        t = 0;
        while (evq.size() == 0 && t < lim) begin
            @(negedge clk);
            t++;
        end
        ok = (evq.size() != 0);
        if (ok) begin
            e = evq.pop_front();
            c = evc.pop_front();
        end else begin
            e = 10'h3FF;
            c = -1;
        end
    endtask

    task automatic flush_events();
        evq.delete();
        evc.delete();
        en_lens.delete();
    endtask

    // Captures the first complete frame that starts after this call.
    task automatic capture_frame();
        bit         ok;
        logic [9:0] e;
        int         c;
        int         k;
        flush_events();
        k = 0;
        do begin
            get_ev(4000, ok, e, c);
            k++;
        end while (ok && e != 10'h200 && k < 60);
        for (int i = 0; i < NW; i++) begin
            get_ev(4000, ok, e, c);
            frame[i] = e[9] ? 9'h1FF : e[8:0];
        end
        get_ev(4000, ok, e, c);
        fp_after = ok && (e == 10'h200);
    endtask

    function automatic logic [8:0] exp_word(input int i);
        int r;
        int p;
        r = i / (COLS + 1);
        p = i % (COLS + 1);
        if (p == 0) return {1'b0, (r == 0) ? 8'h80 : 8'hC0};
        return {1'b1, model[r*COLS + p - 1]};
    endfunction

    task automatic test_reset();
        int n;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (lcd_en !== 1'b0) begin n_fail++; $display("FAIL reset_en: got %b expected 0", lcd_en); end
        n_cmp++; if (lcd_rs !== 1'b0) begin n_fail++; $display("FAIL reset_rs: got %b expected 0", lcd_rs); end
        n_cmp++; if (lcd_rw !== 1'b0) begin n_fail++; $display("FAIL reset_rw: got %b expected 0", lcd_rw); end
        n_cmp++; if (lcd_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", lcd_data); end
        n_cmp++; if ({init_done, frame_pulse, wr_err, wr_ready} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_flags: got %b expected 0000", {init_done, frame_pulse, wr_err, wr_ready});
        end
        flush_events();
        rst = 1'b0;
        rel = cyc;
        n = 0;
        while (!wr_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        n_cmp++; if (n !== 32) begin n_fail++; $display("FAIL reset_clear_len: got %0d expected 32", n); end
    endtask

    task automatic test_init_seq();
        logic [7:0] exp_cmd [6];
        int         cs [6];
        logic [9:0] e;
        int         c;
        bit         ok;
        int         t;
        int         first_len;
        exp_cmd = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
        for (int i = 0; i < 6; i++) begin
            get_ev((i == 0) ? 16000 : 5000, ok, e, c);
            cs[i] = c;
            n_cmp++; if (e !== {2'b00, exp_cmd[i]}) begin
                n_fail++; $display("FAIL init_cmd%0d: got %h expected %h", i, e, {2'b00, exp_cmd[i]});
            end
        end
        n_cmp++; if (init_done !== 1'b0) begin n_fail++; $display("FAIL init_done_early: got %b expected 0", init_done); end
        n_cmp++; if (cs[0] - rel < 15000 || cs[0] - rel > 15005) begin
            n_fail++; $display("FAIL pwrup_delay: got %0d expected 15000..15005", cs[0] - rel);
        end
        first_len = (en_lens.size() > 0) ? en_lens[0] : -1;
        n_cmp++; if (first_len !== 1) begin n_fail++; $display("FAIL en_width: got %0d expected 1", first_len); end
        n_cmp++; if (cs[1] - cs[0] < 4100) begin n_fail++; $display("FAIL fs1_gap: got %0d expected >=4100", cs[1] - cs[0]); end
        n_cmp++; if (cs[2] - cs[1] < 100) begin n_fail++; $display("FAIL fs2_gap: got %0d expected >=100", cs[2] - cs[1]); end
        n_cmp++; if (cs[5] - cs[4] < 1640) begin n_fail++; $display("FAIL clear_gap: got %0d expected >=1640", cs[5] - cs[4]); end
        n_cmp++; if (cs[4] - cs[3] < 40) begin n_fail++; $display("FAIL short_gap: got %0d expected >=40", cs[4] - cs[3]); end
        t = 0;
        while (!init_done && t < 200) begin @(negedge clk); t++; end
        n_cmp++; if (init_done !== 1'b1) begin n_fail++; $display("FAIL init_done: got %b expected 1", init_done); end
    endtask

    task automatic test_write_char();
        @(negedge clk);
        wr_en = 1'b1; wr_row = 2'd1; wr_col = 6'd15; wr_char = 8'h41;
        @(negedge clk);
        wr_row = 2'd0; wr_col = 6'd3; wr_char = 8'h42;
        n_cmp++; if (wr_err !== 1'b0) begin n_fail++; $display("FAIL wr_ok_err1: got %b expected 0", wr_err); end
        @(negedge clk);
        wr_en = 1'b0;
        n_cmp++; if (wr_err !== 1'b0) begin n_fail++; $display("FAIL wr_ok_err2: got %b expected 0", wr_err); end
        model[31] = 8'h41;
        model[3]  = 8'h42;
        capture_frame();
        for (int i = 0; i < NW; i++) begin
            n_cmp++; if (frame[i] !== exp_word(i)) begin
                n_fail++; $display("FAIL wchar_frame[%0d]: got %h expected %h", i, frame[i], exp_word(i));
            end
        end
        n_cmp++; if (fp_after !== 1'b1) begin n_fail++; $display("FAIL wchar_frame_pulse: got %b expected 1", fp_after); end
    endtask

    task automatic test_wr_err();
        @(negedge clk);
        wr_en = 1'b1; wr_row = 2'd2; wr_col = 6'd0; wr_char = 8'h55;
        @(negedge clk);
        wr_row = 2'd0; wr_col = 6'd16;
        n_cmp++; if (wr_err !== 1'b1) begin n_fail++; $display("FAIL err_row: got %b expected 1", wr_err); end
        @(negedge clk);
        wr_en = 1'b0;
        n_cmp++; if (wr_err !== 1'b1) begin n_fail++; $display("FAIL err_col: got %b expected 1", wr_err); end
        @(negedge clk);
        n_cmp++; if (wr_err !== 1'b0) begin n_fail++; $display("FAIL err_pulse_len: got %b expected 0", wr_err); end
        capture_frame();
        for (int i = 0; i < NW; i++) begin
            n_cmp++; if (frame[i] !== exp_word(i)) begin
                n_fail++; $display("FAIL err_frame[%0d]: got %h expected %h", i, frame[i], exp_word(i));
            end
        end
    endtask

    task automatic test_back_to_back();
        int busy_seen;
        busy_seen = 0;
        for (int i = 0; i < ROWS*COLS; i++) begin
            @(negedge clk);
            if (!wr_ready) busy_seen++;
            wr_en = 1'b1; wr_row = 2'(i / COLS); wr_col = 6'(i % COLS); wr_char = 8'h5A;
            model[i] = 8'h5A;
        end
        @(negedge clk);
        wr_en = 1'b0;
        n_cmp++; if (busy_seen !== 0) begin n_fail++; $display("FAIL b2b_ready: got %0d stalls expected 0", busy_seen); end
        capture_frame();
        for (int i = 0; i < NW; i++) begin
            n_cmp++; if (frame[i] !== exp_word(i)) begin
                n_fail++; $display("FAIL fill_frame[%0d]: got %h expected %h", i, frame[i], exp_word(i));
            end
        end
    endtask

    task automatic test_clear();
        int n;
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        n = 0;
        while (!wr_ready && n < 100) begin
            n++;
            if (n == 10) begin
                clr = 1'b1; wr_en = 1'b1; wr_row = 2'd0; wr_col = 6'd0; wr_char = 8'h51;
            end else begin
                clr = 1'b0; wr_en = 1'b0;
            end
            @(negedge clk);
        end
        clr = 1'b0; wr_en = 1'b0;
        n_cmp++; if (n !== 32) begin n_fail++; $display("FAIL clear_len: got %0d expected 32", n); end
        for (int i = 0; i < ROWS*COLS; i++) model[i] = 8'h20;
        capture_frame();
        for (int i = 0; i < NW; i++) begin
            n_cmp++; if (frame[i] !== exp_word(i)) begin
                n_fail++; $display("FAIL clear_frame[%0d]: got %h expected %h", i, frame[i], exp_word(i));
            end
        end
    endtask

    task automatic test_reset_mid_write();
        int         t;
        bit         ok;
        logic [9:0] e;
        int         c;
        t = 0;
        while (lcd_en !== 1'b1 && t < 200) begin @(negedge clk); t++; end
        n_cmp++; if (lcd_en !== 1'b1) begin n_fail++; $display("FAIL mid_find_en: got %b expected 1", lcd_en); end
        rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (lcd_en !== 1'b0) begin n_fail++; $display("FAIL mid_en: got %b expected 0", lcd_en); end
        n_cmp++; if ({lcd_rs, lcd_data} !== 9'h000) begin
            n_fail++; $display("FAIL mid_bus: got %h expected 000", {lcd_rs, lcd_data});
        end
        n_cmp++; if (init_done !== 1'b0) begin n_fail++; $display("FAIL mid_init_done: got %b expected 0", init_done); end
        @(negedge clk);
        @(negedge clk);
        flush_events();
        rst = 1'b0;
        rel = cyc;
        get_ev(16000, ok, e, c);
        n_cmp++; if (e !== 10'h038) begin n_fail++; $display("FAIL restart_cmd: got %h expected 038", e); end
        n_cmp++; if (c - rel < 15000 || c - rel > 15005) begin
            n_fail++; $display("FAIL restart_delay: got %0d expected 15000..15005", c - rel);
        end
    endtask

    task automatic test_bus_protocol();
        n_cmp++; if (setup_viol !== 0) begin n_fail++; $display("FAIL setup_hold: got %0d violations expected 0", setup_viol); end
        n_cmp++; if (rw_viol !== 0) begin n_fail++; $display("FAIL rw_low: got %0d violations expected 0", rw_viol); end
    endtask

    initial begin
        for (int i = 0; i < ROWS*COLS; i++) model[i] = 8'h20;
        test_reset();
        test_init_seq();
        test_write_char();
        test_wr_err();
        test_back_to_back();
        test_clear();
        test_reset_mid_write();
        test_bus_protocol();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
